param_memory: RTL
=================

PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 Parameter DW, default 16: data word width; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 16: address width.
REQ-003 Parameter DEPTH, default 4096: number of words; SHALL be at most 2^AW.
REQ-004 Parameter LAT, default 1: read/response latency in cycles; legal range 1..4.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 init_req  in  1  pulse requesting a zero-fill sweep of the whole array.
REQ-008 init_busy  out  1  high while a zero-fill sweep is in progress.
REQ-009 req_valid  in  1  request present.
REQ-010 req_ready  out  1  block can accept a request this cycle.
REQ-011 req_wen  in  1  1 = write, 0 = read.
REQ-012 req_be  in  DW/8  byte enables for writes; bit i covers data bits [8i+7:8i].
REQ-013 req_addr  in  AW  word address.
REQ-014 req_wdata  in  DW  write data.
REQ-015 rsp_valid  out  1  one-cycle response strobe.
REQ-016 rsp_rdata  out  DW  read data; valid only with rsp_valid.
REQ-017 rsp_err  out  1  address-out-of-range flag; valid only with rsp_valid.

Function
REQ-018 FSM SHALL have two states: CLEAR (sweep running) and IDLE (serving requests).
REQ-019 CLEAR: one word per cycle, zero written to addresses 0..DEPTH-1 in order; init_busy=1 and req_ready=0 throughout; after writing DEPTH-1 -> IDLE on the next edge.
REQ-020 IDLE: req_ready=1 and init_busy=0; init_req=1 -> CLEAR with sweep counter at 0.
REQ-021 init_req SHALL be ignored while in CLEAR; the sweep is not restarted.
REQ-022 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
REQ-023 Accepted write, req_addr < DEPTH: only bytes with req_be=1 SHALL be updated at the accept edge; other bytes keep their contents.
REQ-024 Every accepted request, read or write, SHALL produce exactly one response with rsp_valid=1 exactly LAT cycles after the accept edge.
REQ-025 Read response SHALL carry the word as stored at the accept edge, including any write accepted on an earlier edge; back-to-back write then read of the same address returns the new data.
REQ-026 Write response SHALL have rsp_rdata=0 and rsp_err=0.
REQ-027 Address >= DEPTH: no array update; response has rsp_err=1 and rsp_rdata=0.
REQ-028 Responses SHALL be pipelined with no backpressure; a new request may be accepted every IDLE cycle, giving one response per cycle at full throughput.
REQ-029 init_req and an accepted request on the same edge: the request is served first; CLEAR starts on that edge, and the request's response is still delivered LAT cycles later.
REQ-030 Responses still in flight when CLEAR is entered SHALL be delivered unchanged.
REQ-031 rsp_rdata and rsp_err SHALL be 0 on any cycle where rsp_valid=0.

Reset
REQ-032 While rst=0: FSM in CLEAR with sweep counter 0; rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_busy=1; response pipeline flushed.
REQ-033 Array contents SHALL NOT be reset directly; they are zeroed by the sweep that starts when rst is released.
REQ-034 Reset asserted mid-sweep or mid-pipeline SHALL flush all pending responses and restart the sweep from address 0 after release.

Verification (DW=16, DEPTH=16, LAT=2 unless stated)
REQ-035 Release reset -> init_busy=1 for exactly 16 cycles, then req_ready=1; a read of each of addresses 0..15 returns 0000 with rsp_err=0.
REQ-036 Write addr 3, data A5C3, be=11; read addr 3 on the next cycle -> rsp_valid 2 cycles after each accept; read returns A5C3.
REQ-037 Write addr 5, data FFFF, be=11; then write addr 5, data 1234, be=01 -> read addr 5 returns FF34.
REQ-038 Read addr 20 -> rsp_err=1, rsp_rdata=0000; array contents unchanged.
REQ-039 Streaming reads of addresses 0..7 on consecutive cycles, with init_req asserted on the same edge as the accept of address 7 -> all 8 responses arrive in order, then init_busy=1 for 16 cycles.
REQ-040 Sweep with LAT=1 and with LAT=4: rst pulled low at sweep address 8 -> after release, the sweep restarts at 0; no response is emitted before the first post-sweep accept.

Source files
------------

// File: rtl/param_memory.sv
// ---------------------------------------------------------------------------
// param_memory
//   Single-port word memory with byte-enabled writes, a fixed-latency
//   response pipeline, and a self-contained zero-fill sweep. The sweep runs
//   after reset is released and on request (init_req). While the sweep runs,
//   no requests are accepted.
//
// Parameters
//   DW    : data width, a multiple of 8
//   AW    : address width
//   DEPTH : number of words, at most 2**AW
//   LAT   : response latency in cycles, 1..4
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : asynchronous active-low reset
//   init_req   : pulse that starts a zero-fill sweep (ignored while sweeping)
//   init_busy  : high while the sweep is running
//   req_valid  : request present
//   req_ready  : request can be accepted this cycle
//   req_wen    : 1 = write, 0 = read
//   req_be     : byte enables for writes
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : one-cycle response strobe, LAT cycles after the accept edge
//   rsp_rdata  : read data (zero for writes, errors and idle cycles)
//   rsp_err    : address out of range (zero on idle cycles)
// ---------------------------------------------------------------------------
module param_memory #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 4096,
    parameter int LAT   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_req,
    output logic            init_busy,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [DW/8-1:0] req_be,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err
);

    // Index width into the array; the upper address bits only matter for the
    // range check.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_sweep_idx;

    logic [DW-1:0] r_mem [DEPTH];

    logic          r_pv [LAT];
    logic [DW-1:0] r_pd [LAT];
    logic          r_pe [LAT];

    logic          w_accept;
    logic          w_in_range;
    logic [IW-1:0] w_idx;

    assign req_ready  = (r_state == ST_IDLE);
    assign init_busy  = (r_state == ST_CLEAR);
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = ({1'b0, req_addr} < DEPTH_W);
    assign w_idx      = req_addr[IW-1:0];

    // Sweep FSM. An accepted request on the same edge as init_req is still
    // served (array write / read capture below); CLEAR begins on that edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_CLEAR;
            r_sweep_idx <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_sweep_idx == LAST_IDX) begin
                        r_state     <= ST_IDLE;
                        r_sweep_idx <= '0;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + 1'b1;
                    end
                end
                default: begin
                    if (init_req) begin
                        r_state     <= ST_CLEAR;
                        r_sweep_idx <= '0;
                    end
                end
            endcase
        end
    end

    // Array writes: sweep zeroes one word per cycle; otherwise byte-enabled
    // writes from accepted in-range requests.
    // NOTE: the array has no reset term; it is cleared by the sweep that
    // follows reset release, which keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_sweep_idx] <= '0;
        end else if (w_accept && req_wen && w_in_range) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (req_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline. Stage 0 is loaded at the accept edge; the read
    // captures the pre-edge array word, which already holds any write from
    // an earlier edge. Data and error are forced to zero whenever the stage
    // is empty, so the outputs are clean without extra gating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
                r_pe[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pe[0] <= w_accept && !w_in_range;
            r_pd[0] <= (w_accept && !req_wen && w_in_range) ? r_mem[w_idx] : '0;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    assign rsp_valid = r_pv[LAT-1];
    assign rsp_rdata = r_pd[LAT-1];
    assign rsp_err   = r_pe[LAT-1];

endmodule
